// File: rtl/gf2m_serial_multiplier.sv
// Bit-serial GF(2^M) multiply / square / inverse engine with a programmable irreducible polynomial.
// One shared MSB-first shift-and-add datapath; inversion runs Fermat's square-and-multiply chain.
module gf2m_serial_multiplier #(
    parameter int unsigned M    = 4,
    parameter logic [M:0]  POLY = 5'b10011
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [1:0]   in_op_i,
    input  logic [M-1:0] in_a_i,
    input  logic [M-1:0] in_b_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [M-1:0] out_c_o,
    output logic         out_err_o,
    output logic         busy_o
);

    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

    if (M < 2 || M > 16) begin : g_bad_m
        $error("gf2m_serial_multiplier: M must be in 2..16");
    end
    if (POLY[M] != 1'b1 || POLY[0] != 1'b1) begin : g_bad_poly
        $error("gf2m_serial_multiplier: POLY must have bits M and 0 set");
    end

    typedef enum logic [1:0] {StIdle, StSqr, StMul, StDone} state_e;

    state_e          state_q, state_d;
    logic [M-1:0]    acc_q, acc_d;
    logic [M-1:0]    x_q, x_d;
    logic [M-1:0]    y_q, y_d;
    logic [M-1:0]    r_q, r_d;
    logic [M-1:0]    s_q, s_d;
    logic [M-1:0]    c_q, c_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   iter_q, iter_d;
    logic            inv_q, inv_d;
    logic            ill_q, ill_d;
    logic            oerr_q, oerr_d;

    logic [M:0]      shifted;
    logic [M-1:0]    acc_step;
    logic            last_step;

    always_comb begin
        shifted = {acc_q, 1'b0};
        if (shifted[M]) begin
            shifted = shifted ^ POLY;
        end
        acc_step  = shifted[M-1:0] ^ (y_q[cnt_q] ? x_q : '0);
        last_step = (cnt_q == '0);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        iter_d  = iter_q;
        inv_d   = inv_q;
        ill_d   = ill_q;
        oerr_d  = oerr_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    acc_d = '0;
                    cnt_d = CW'(M - 1);
                    inv_d = 1'b0;
                    ill_d = 1'b0;
                    unique case (in_op_i)
                        2'b00: begin
                            x_d     = in_a_i;
                            y_d     = in_b_i;
                            oerr_d  = 1'b0;
                            state_d = StMul;
                        end
                        2'b01: begin
                            x_d     = in_a_i;
                            y_d     = in_a_i;
                            oerr_d  = 1'b0;
                            state_d = StMul;
                        end
                        2'b10: begin
                            r_d     = {{(M-1){1'b0}}, 1'b1};
                            s_d     = in_a_i;
                            x_d     = in_a_i;
                            y_d     = in_a_i;
                            iter_d  = CW'(1);
                            inv_d   = 1'b1;
                            oerr_d  = 1'b0;
                            state_d = StSqr;
                        end
                        default: begin
                            // Illegal op spends one cycle in MUL so the error result
                            // appears one cycle after the handshake.
                            ill_d   = 1'b1;
                            state_d = StMul;
                        end
                    endcase
                end
            end
            StSqr: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                if (last_step) begin
                    s_d     = acc_step;
                    x_d     = r_q;
                    y_d     = acc_step;
                    acc_d   = '0;
                    cnt_d   = CW'(M - 1);
                    state_d = StMul;
                end
            end
            StMul: begin
                if (ill_q) begin
                    c_d     = '0;
                    oerr_d  = 1'b1;
                    ill_d   = 1'b0;
                    state_d = StDone;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - 1'b1;
                    if (last_step) begin
                        if (!inv_q) begin
                            c_d     = acc_step;
                            state_d = StDone;
                        end else begin
                            r_d = acc_step;
                            if (iter_q == CW'(M - 1)) begin
                                c_d     = acc_step;
                                state_d = StDone;
                            end else begin
                                iter_d  = iter_q + 1'b1;
                                x_d     = s_q;
                                y_d     = s_q;
                                acc_d   = '0;
                                cnt_d   = CW'(M - 1);
                                state_d = StSqr;
                            end
                        end
                    end
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            iter_q  <= '0;
            inv_q   <= 1'b0;
            ill_q   <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
            inv_q   <= inv_d;
            ill_q   <= ill_d;
            oerr_q  <= oerr_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign out_valid_o = (state_q == StDone);
    assign out_c_o     = c_q;
    assign out_err_o   = oerr_q;

endmodule

// File: tb/tb_gf2m_serial_multiplier.sv
// Bench for the serial GF(2^M) engine: a GF(16) instance and an AES GF(256) instance, both
// checked each cycle against a plain polynomial-arithmetic model.
module tb_gf2m_serial_multiplier;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]      iv, ordy;
    logic [1:0][1:0] op;
    logic [1:0][7:0] a_s, b_s;

    logic       ir4, ov4, oe4, bz4;
    logic       ir8, ov8, oe8, bz8;
    logic [3:0] c4;
    logic [7:0] c8;

    logic [1:0]      ir, ov, oe, bz;
    logic [1:0][7:0] c_s;
    assign ir  = {ir8, ir4};
    assign ov  = {ov8, ov4};
    assign oe  = {oe8, oe4};
    assign bz  = {bz8, bz4};
    assign c_s = {c8, 4'b0000, c4};

    gf2m_serial_multiplier #(.M(4), .POLY(5'b10011)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (iv[0]),
        .in_ready_o  (ir4),
        .in_op_i     (op[0]),
        .in_a_i      (a_s[0][3:0]),
        .in_b_i      (b_s[0][3:0]),
        .out_valid_o (ov4),
        .out_ready_i (ordy[0]),
        .out_c_o     (c4),
        .out_err_o   (oe4),
        .busy_o      (bz4)
    );

    gf2m_serial_multiplier #(.M(8), .POLY(9'h11B)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (iv[1]),
        .in_ready_o  (ir8),
        .in_op_i     (op[1]),
        .in_a_i      (a_s[1]),
        .in_b_i      (b_s[1]),
        .out_valid_o (ov8),
        .out_ready_i (ordy[1]),
        .out_c_o     (c8),
        .out_err_o   (oe8),
        .busy_o      (bz8)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Schoolbook carry-less product followed by long division by the field polynomial.
    function automatic int gmul(input int a, input int b, input int m, input int poly);
        int r = 0;
        for (int i = 0; i < m; i++) begin
            if (((b >> i) & 1) != 0) r ^= (a << i);
        end
        for (int i = 2 * m - 2; i >= m; i--) begin
            if (((r >> i) & 1) != 0) r ^= (poly << (i - m));
        end
        return r;
    endfunction

    function automatic int ginv(input int a, input int m, input int poly);
        if (a == 0) return 0;
        for (int x = 1; x < (1 << m); x++) begin
            if (gmul(a, x, m, poly) == 1) return x;
        end
        return -1;
    endfunction

    bit [1:0] pend;
    int       t0[2];
    int       expc[2];
    int       experr[2];
    int       explat[2];

    // Cycle-level compare: latency, result, error flag and handshake signals for both engines.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                int m, poly, a, b;
                m    = (d == 0) ? 4 : 8;
                poly = (d == 0) ? 'h13 : 'h11B;
                chk("busy_vs_ready", {31'b0, bz[d]}, {31'b0, !ir[d]});
                if (pend[d]) begin
                    chk("in_ready_while_busy", {31'b0, ir[d]}, 32'd0);
                    if (cyc - t0[d] < explat[d]) begin
                        chk("out_valid_early", {31'b0, ov[d]}, 32'd0);
                    end else begin
                        chk("out_valid", {31'b0, ov[d]}, 32'd1);
                        if (ov[d]) begin
                            chk("out_c", {24'b0, c_s[d]}, expc[d]);
                            chk("out_err", {31'b0, oe[d]}, experr[d]);
                            if (ordy[d]) pend[d] = 1'b0;
                        end
                    end
                end else begin
                    chk("idle_ready", {31'b0, ir[d]}, 32'd1);
                    chk("idle_valid", {31'b0, ov[d]}, 32'd0);
                end
                if (iv[d] && ir[d]) begin
                    a = int'(a_s[d]) & ((1 << m) - 1);
                    b = int'(b_s[d]) & ((1 << m) - 1);
                    pend[d]   = 1'b1;
                    t0[d]     = cyc + 1;
                    experr[d] = 0;
                    case (op[d])
                        2'b00: begin expc[d] = gmul(a, b, m, poly); explat[d] = m; end
                        2'b01: begin expc[d] = gmul(a, a, m, poly); explat[d] = m; end
                        2'b10: begin expc[d] = ginv(a, m, poly); explat[d] = 2 * m * (m - 1); end
                        default: begin expc[d] = 0; experr[d] = 1; explat[d] = 1; end
                    endcase
                end
            end
        end
    end

    task automatic send(input int d, input int o, input int a, input int b);
        int got = 0;
        @(posedge clk); #1;
        iv[d]  = 1'b1;
        op[d]  = 2'(o);
        a_s[d] = 8'(a);
        b_s[d] = 8'(b);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ir[d]) begin got = 1; break; end
        end
        chk("request_accepted", got, 1);
        @(posedge clk); #1;
        iv[d]  = 1'b0;
        op[d]  = 2'($urandom);
        a_s[d] = 8'($urandom);
        b_s[d] = 8'($urandom);
    endtask

    // Waits for the result, stalls the consumer for hold cycles while poking in_valid, then drains.
    task automatic result(input int d, input int hold, output int c, output int e);
        int got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ov[d]) begin got = 1; break; end
        end
        chk("result_arrives", got, 1);
        c = int'(c_s[d]);
        e = int'(oe[d]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            iv[d]  = 1'b1;
            op[d]  = 2'($urandom);
            a_s[d] = 8'($urandom);
            b_s[d] = 8'($urandom);
        end
        @(posedge clk); #1;
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
    endtask

    task automatic do_op(input int d, input int o, input int a, input int b, input int hold,
                         output int c, output int e);
        send(d, o, a, b);
        result(d, hold, c, e);
    endtask

    initial begin
        int c, e, p;
        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        op    = '0;
        a_s   = '0;
        b_s   = '0;
        #12;
        chk("reset_out_valid", {31'b0, ov4}, 32'd0);
        chk("reset_in_ready", {31'b0, ir4}, 32'd1);
        chk("reset_out_c", {28'b0, c4}, 32'd0);
        chk("reset_out_err", {31'b0, oe4}, 32'd0);
        chk("reset_busy", {31'b0, bz8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 0, 'h3, 'h7, 0, c, e); chk("mul_3_7", c, 'h9);
        do_op(0, 0, 'hF, 'h1, 0, c, e); chk("mul_f_1", c, 'hF);
        do_op(0, 0, 'h0, 'hA, 0, c, e); chk("mul_0_a", c, 'h0);
        do_op(0, 1, 'h8, 'h0, 0, c, e); chk("sqr_8", c, 'hC);
        do_op(0, 2, 'h2, 'h0, 0, c, e); chk("inv_2", c, 'h9);
        do_op(0, 2, 'h0, 'h0, 0, c, e); chk("inv_0", c, 'h0); chk("inv_0_err", e, 0);
        do_op(0, 3, 'h5, 'h0, 0, c, e); chk("illegal_c", c, 'h0); chk("illegal_err", e, 1);
        do_op(0, 0, 'h3, 'h7, 0, c, e); chk("err_cleared", e, 0);
        do_op(0, 0, 'h5, 'h6, 10, c, e); chk("backpressure_c", c, 'hD);
        do_op(0, 1, 'h2, 'h0, 0, c, e); chk("after_backpressure", c, 'h4);

        // Abort a multiply two steps in; reset must clear outputs without waiting for a clock.
        send(0, 0, 'h3, 'h7);
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'b0, ov4}, 32'd0);
        chk("abort_out_c", {28'b0, c4}, 32'd0);
        chk("abort_in_ready", {31'b0, ir4}, 32'd1);
        chk("abort_busy", {31'b0, bz4}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 0, 'h3, 'h7, 0, c, e); chk("post_reset_mul", c, 'h9);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(0, 0, a, b, 0, c, e);
            end
        end
        for (int a = 1; a < 16; a++) begin
            do_op(0, 2, a, 0, 0, c, e);
            do_op(0, 0, a, c, 0, p, e);
            chk("gf16_a_times_inv", p, 1);
        end

        do_op(1, 2, 'h53, 0, 0, c, e); chk("aes_inv_53", c, 'hCA);
        do_op(1, 0, 'h57, 'h83, 0, c, e); chk("aes_mul_57_83", c, 'hC1);
        for (int i = 0; i < 4; i++) begin
            int a;
            a = int'($urandom_range(1, 255));
            do_op(1, 2, a, 0, 0, c, e);
            do_op(1, 0, a, c, 0, p, e);
            chk("gf256_a_times_inv", p, 1);
        end

        for (int i = 0; i < 60; i++) begin
            int d, o;
            d = int'($urandom_range(0, 1));
            o = int'($urandom_range(0, 3));
            if (d == 1 && o == 2 && ($urandom_range(0, 3) != 0)) o = 0;
            do_op(d, o, int'($urandom), int'($urandom), int'($urandom_range(0, 3)), c, e);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
